// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : MIPS instruction-fetch stage. It holds the PC, selects the next
//               PC, issues inst SRAM reads and buffers stalled instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] EXC_PC   = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata
);

    logic        w_br_stall;
    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_to_fs_valid;
    logic        w_fs_allowin;
    logic        w_br_stall_eff;
    logic        w_redirect;
    logic        w_accept;
    logic [31:0] w_nextpc;
    logic [31:0] w_inst;

    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic        r_br_pending;
    logic [31:0] r_br_target;
    logic        r_ibuf_valid;
    logic [31:0] r_ibuf;

    assign {w_br_stall, w_br_taken, w_br_target} = br_bus;

    assign w_to_fs_valid  = ~reset;
    assign w_fs_allowin   = ~r_fs_valid | ds_allowin;
    assign w_br_stall_eff = w_br_stall & w_br_taken & ~flush;
    assign inst_sram_en   = w_to_fs_valid & (w_fs_allowin | flush) & ~w_br_stall_eff;

    // A redirect is only legal once the delay slot sits in IF.
    assign w_redirect = w_br_taken & r_fs_valid & ~w_br_stall & ~r_br_pending & ~flush;

    always_comb begin
        w_nextpc = r_fs_pc + 32'd4;
        if (flush) begin
            w_nextpc = EXC_PC;
        end else if (r_br_pending) begin
            w_nextpc = r_br_target;
        end else if (w_br_taken && r_fs_valid) begin
            w_nextpc = w_br_target;
        end
    end

    assign inst_sram_addr = w_nextpc;

    assign w_inst         = r_ibuf_valid ? r_ibuf : inst_sram_rdata;
    assign fs_to_ds_valid = r_fs_valid & ~flush;
    assign fs_to_ds_bus   = {w_inst, r_fs_pc};
    assign w_accept       = fs_to_ds_valid & ds_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs_valid <= 1'b0;
            r_fs_pc    <= RESET_PC - 32'd4;
        end else if (inst_sram_en) begin
            r_fs_valid <= 1'b1;
            r_fs_pc    <= w_nextpc;
        end else if (w_accept) begin
            r_fs_valid <= 1'b0;
        end
    end

    // Redirect chosen while IF is full: remember the target until it can issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_pending <= 1'b0;
            r_br_target  <= 32'd0;
        end else if (flush) begin
            r_br_pending <= 1'b0;
        end else if (r_br_pending && inst_sram_en) begin
            r_br_pending <= 1'b0;
        end else if (w_redirect && !inst_sram_en) begin
            r_br_pending <= 1'b1;
            r_br_target  <= w_br_target;
        end
    end

    // SRAM data is only valid the cycle after the request, so hold it on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ibuf_valid <= 1'b0;
            r_ibuf       <= 32'd0;
        end else if (inst_sram_en || flush) begin
            r_ibuf_valid <= 1'b0;
        end else if (r_fs_valid && !ds_allowin && !r_ibuf_valid) begin
            r_ibuf_valid <= 1'b1;
            r_ibuf       <= inst_sram_rdata;
        end else if (w_accept) begin
            r_ibuf_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Table-driven bench for if_stage with a delivered-instruction
//               scoreboard and a one-cycle-latency inst SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] c_reset_pc = 32'hBFC0_0000;
    localparam logic [31:0] c_exc_pc   = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        ds_allowin;
    logic [33:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        corrupt;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC(c_reset_pc),
        .EXC_PC  (c_exc_pc)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // SRAM: data for a request appears one cycle later; "corrupt" changes the
    // output while no request is pending so buffered data can be told apart.
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= mem(inst_sram_addr);
        else if (corrupt)
            inst_sram_rdata <= 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        rst;
        logic        fl;
        logic        dsa;
        logic        st;
        logic        tk;
        logic [31:0] tg;
        logic        cr;
        logic        en;
        logic [31:0] ad;
        logic        vl;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb[$];
    int          checks = 0;
    int          fails  = 0;
    int          cur    = -1;

    task automatic add(input logic rst, input logic fl, input logic dsa, input logic st,
                       input logic tk, input logic [31:0] tg, input logic cr,
                       input logic en, input logic [31:0] ad, input logic vl);
        vec_t v;
        v.rst = rst; v.fl = fl; v.dsa = dsa; v.st = st; v.tk = tk; v.tg = tg;
        v.cr = cr; v.en = en; v.ad = ad; v.vl = vl;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, cur, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset      = v.rst;
        flush      = v.fl;
        ds_allowin = v.dsa;
        br_bus     = {v.st, v.tk, v.tg};
        corrupt    = v.cr;
    endtask

    task automatic sample(input vec_t v);
        check("inst_sram_en", {63'd0, inst_sram_en}, {63'd0, v.en});
        if (v.en) check("inst_sram_addr", {32'd0, inst_sram_addr}, {32'd0, v.ad});
        check("fs_to_ds_valid", {63'd0, fs_to_ds_valid}, {63'd0, v.vl});
        // The instruction sitting in IF is discarded by a flush.
        if (v.fl && sb.size() > 0) sb.pop_back();
        if (fs_to_ds_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL fs_to_ds_bus (vector %0d): got %h, expected no instruction", cur, fs_to_ds_bus);
            end else begin
                check("fs_to_ds_bus", fs_to_ds_bus, sb[0]);
                if (ds_allowin) sb.pop_front();
            end
        end
        if (v.rst) sb.delete();
        if (v.en) sb.push_back({mem(v.ad), v.ad});
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        ds_allowin = 1'b1;
        br_bus     = '0;
        corrupt    = 1'b0;

        //  rst fl dsa st tk target         cr en addr                     vl
        // Sequential fetch after reset
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, c_reset_pc,              0);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, c_reset_pc + 32'h4,      1);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, c_reset_pc + 32'h8,      1);
        // Decode stall at BFC00008 while SRAM output changes
        add(0, 0, 0, 0, 0, 32'h0,          1, 0, 32'h0,                   1);
        add(0, 0, 0, 0, 0, 32'h0,          1, 0, 32'h0,                   1);
        add(0, 0, 0, 0, 0, 32'h0,          1, 0, 32'h0,                   1);
        add(0, 0, 0, 0, 0, 32'h0,          1, 0, 32'h0,                   1);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, c_reset_pc + 32'hC,      1);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, c_reset_pc + 32'h10,     1);
        // Taken branch with delay slot BFC00010 in IF
        add(0, 0, 1, 0, 1, 32'h8000_1000,  0, 1, 32'h8000_1000,           1);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, 32'h8000_1004,           1);
        // Branch stalled two cycles
        add(0, 0, 0, 1, 1, 32'h8000_2000,  0, 0, 32'h0,                   1);
        add(0, 0, 0, 1, 1, 32'h8000_2000,  0, 0, 32'h0,                   1);
        add(0, 0, 1, 0, 1, 32'h8000_2000,  0, 1, 32'h8000_2000,           1);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, 32'h8000_2004,           1);
        // Branch while IF is full -> pending; a second taken is ignored
        add(0, 0, 0, 0, 1, 32'h8000_3000,  0, 0, 32'h0,                   1);
        add(0, 0, 0, 0, 1, 32'h8000_4000,  0, 0, 32'h0,                   1);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, 32'h8000_3000,           1);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, 32'h8000_3004,           1);
        // Pending branch plus buffered inst, then flush
        add(0, 0, 0, 0, 1, 32'h8000_5000,  1, 0, 32'h0,                   1);
        add(0, 0, 0, 0, 0, 32'h0,          1, 0, 32'h0,                   1);
        add(0, 1, 0, 0, 0, 32'h0,          0, 1, c_exc_pc,                0);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, c_exc_pc + 32'h4,        1);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, c_exc_pc + 32'h8,        1);
        // PC wraps modulo 2^32
        add(0, 0, 1, 0, 1, 32'hFFFF_FFFC,  0, 1, 32'hFFFF_FFFC,           1);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, 32'h0000_0000,           1);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, 32'h0000_0004,           1);
        // Reset in the middle of fetching
        add(1, 0, 1, 0, 0, 32'h0,          0, 0, 32'h0,                   1);
        add(1, 0, 1, 0, 0, 32'h0,          0, 0, 32'h0,                   0);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, c_reset_pc,              0);
        add(0, 0, 1, 0, 0, 32'h0,          0, 1, c_reset_pc + 32'h4,      1);

        // Reset state after three reset cycles
        repeat (3) @(posedge clk);
        #1;
        check("reset inst_sram_en", {63'd0, inst_sram_en}, 64'd0);
        check("reset fs_to_ds_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        check("reset fs_pc", {32'd0, fs_to_ds_bus[31:0]}, {32'd0, c_reset_pc - 32'd4});

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            drive(vecs[i]);
            @(negedge clk);
            sample(vecs[i]);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
